// File: rtl/sisc_fetch_unit.sv
// rtl/sisc_fetch_unit.sv - SISC instruction fetch: PC, IR, branch targets, optional FETCH_STALL_EN wait-state handshake
module sisc_fetch_unit #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              pc_rst,
    input  logic              pc_write,
    input  logic              pc_sel,
    input  logic              br_sel,
    input  logic              ir_load,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    output logic              fetch_busy,
    output logic [ADDR_W-1:0] pc_out,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [3:0]        rn,
    output logic [3:0]        rs,
    output logic [3:0]        rt,
    output logic [ADDR_W-1:0] imm
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;

    // Field decode: plain slices of the held instruction word
    assign opcode = ir_q[31:28];
    assign mm     = ir_q[27:24];
    assign rn     = ir_q[23:20];
    assign rs     = ir_q[19:16];
    assign rt     = ir_q[15:12];
    assign imm    = ir_q[ADDR_W-1:0];
    assign pc_out = pc_q;

    // Next PC: synchronous clear beats every update; relative branches add imm to the current PC
    always_comb begin
        pc_d = pc_q;
        if (pc_rst) begin
            pc_d = '0;
        end else if (pc_write) begin
            if (!pc_sel) begin
                pc_d = pc_q + ADDR_W'(1);
            end else if (br_sel) begin
                pc_d = imm;
            end else begin
                pc_d = pc_q + imm;
            end
        end
    end

    // PC and IR registers
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q <= '0;
            ir_q <= '0;
        end else begin
            pc_q <= pc_d;
            ir_q <= ir_d;
        end
    end

`ifdef FETCH_STALL_EN
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fa_q, fa_d;

    // Busy is a pure state decode so ctrl never sees an input-to-output path through it
    assign fetch_busy = (state_q == ST_WAIT);

    // Fetch handshake: IDLE issues from the live PC, WAIT replays the latched address until data or abort
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        fa_d      = fa_q;
        imem_addr = pc_q;
        imem_rd   = ir_load;
        if (state_q == ST_IDLE) begin
            if (ir_load) begin
                fa_d = pc_q;
                if (imem_valid) begin
                    ir_d = imem_rdata;
                end else begin
                    state_d = ST_WAIT;
                end
            end
        end else begin
            imem_addr = fa_q;
            imem_rd   = 1'b1;
            if (pc_rst) begin
                state_d = ST_IDLE;
            end else if (imem_valid) begin
                ir_d    = imem_rdata;
                state_d = ST_IDLE;
            end
        end
    end

    // Handshake state and latched fetch address
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= ST_IDLE;
            fa_q    <= '0;
        end else begin
            state_q <= state_d;
            fa_q    <= fa_d;
        end
    end
`else
    logic unused_imem_valid;

    assign unused_imem_valid = imem_valid;
    assign fetch_busy        = 1'b0;
    assign imem_rd           = ir_load;
    assign imem_addr         = pc_q;

    // Single-cycle memory: every fetch strobe captures the returned word
    always_comb begin
        ir_d = ir_q;
        if (ir_load) begin
            ir_d = imem_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// tb/tb_sisc_fetch_unit.sv - self-checking bench for sisc_fetch_unit
module tb_sisc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        pc_rst, pc_write, pc_sel, br_sel, ir_load, imem_valid;
    logic [31:0] imem_rdata;
    logic [15:0] imem_addr, pc_out, imm;
    logic        imem_rd, fetch_busy;
    logic [3:0]  opcode, mm, rn, rs, rt;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic [15:0] m_pend[$];
    logic [15:0] obs_addr;
    logic        obs_busy;
    int          busy_n;

    always #5 clk = ~clk;

    sisc_fetch_unit #(.ADDR_W(16)) dut (
        .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
        .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .fetch_busy(fetch_busy),
        .pc_out(pc_out), .opcode(opcode), .mm(mm), .rn(rn), .rs(rs), .rt(rt),
        .imm(imm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_ir = '0;
        m_pend.delete();
    endtask

    // Reference: one clock edge computed from the architectural rules
    task automatic model_edge();
        logic [15:0] pc_v;
        logic [15:0] imm_v;
        pc_v  = m_pc;
        imm_v = m_ir[15:0];
`ifdef FETCH_STALL_EN
        if (m_pend.size() != 0) begin
            if (pc_rst) begin
                m_pend.delete();
            end else if (imem_valid) begin
                m_ir = imem_rdata;
                m_pend.delete();
            end
        end else if (ir_load) begin
            if (imem_valid) m_ir = imem_rdata;
            else m_pend.push_back(pc_v);
        end
`else
        if (ir_load) m_ir = imem_rdata;
`endif
        if (pc_rst) m_pc = 16'd0;
        else if (pc_write) begin
            if (!pc_sel) m_pc = pc_v + 16'd1;
            else if (br_sel) m_pc = imm_v;
            else m_pc = pc_v + imm_v;
        end
    endtask

    task automatic check_regs();
        check("pc_out", pc_out, m_pc);
        check("opcode", opcode, m_ir[31:28]);
        check("mm", mm, m_ir[27:24]);
        check("rn", rn, m_ir[23:20]);
        check("rs", rs, m_ir[19:16]);
        check("rt", rt, m_ir[15:12]);
        check("imm", imm, m_ir[15:0]);
    endtask

    task automatic cyc(input logic ld, input logic vld, input logic [31:0] rd,
                       input logic pw, input logic ps, input logic bs, input logic pr);
        logic pend;
        ir_load = ld; imem_valid = vld; imem_rdata = rd;
        pc_write = pw; pc_sel = ps; br_sel = bs; pc_rst = pr;
        #3;
        pend     = (m_pend.size() != 0);
        obs_addr = imem_addr;
        obs_busy = fetch_busy;
        check("imem_addr", imem_addr, pend ? m_pend[0] : m_pc);
        check("imem_rd", imem_rd, pend ? 1'b1 : ld);
        check("fetch_busy", fetch_busy, pend);
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic set_pc(input logic [15:0] v);
        cyc(1'b1, 1'b1, {16'h0000, v}, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst_f = 1'b0;
        pc_rst = 0; pc_write = 0; pc_sel = 0; br_sel = 0; ir_load = 0;
        imem_valid = 0; imem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc_out, 16'h0);
        check("rst_opcode", opcode, 4'h0);
        check("rst_imm", imm, 16'h0);
        check("rst_busy", fetch_busy, 1'b0);
        check("rst_rd", imem_rd, 1'b0);
        check("rst_addr", imem_addr, 16'h0);
        rst_f = 1'b1;

        // Sequential fetch from PC=5
        repeat (5) cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("pc_is_5", pc_out, 16'd5);
        cyc(1'b1, 1'b1, 32'h81234007, 1'b1, 1'b0, 1'b0, 1'b0);
        check("seq_addr", obs_addr, 16'd5);
        check("seq_pc", pc_out, 16'd6);
        check("seq_opcode", opcode, 4'd8);
        check("seq_mm", mm, 4'd1);
        check("seq_rn", rn, 4'd2);
        check("seq_rs", rs, 4'd3);
        check("seq_rt", rt, 4'd4);
        check("seq_imm", imm, 16'h4007);

        // Branches
        set_pc(16'h0010);
        cyc(1'b1, 1'b1, 32'h00000020, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("br_abs", pc_out, 16'h0020);
        set_pc(16'h0010);
        cyc(1'b1, 1'b1, 32'h00000020, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("br_rel", pc_out, 16'h0030);
        set_pc(16'h0010);
        cyc(1'b1, 1'b1, 32'h0000FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("br_wrap", pc_out, 16'h000E);

`ifdef FETCH_STALL_EN
        // Three wait states at PC=7 with a redundant ir_load mid-wait
        set_pc(16'h0007);
        busy_n = 0;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        busy_n += int'(obs_busy);
        check("ws_addr1", obs_addr, 16'd7);
        cyc(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0, 1'b0, 1'b0);
        busy_n += int'(obs_busy);
        check("ws_addr2", obs_addr, 16'd7);
        cyc(1'b0, 1'b1, 32'hA5A51234, 1'b0, 1'b0, 1'b0, 1'b0);
        busy_n += int'(obs_busy);
        check("ws_addr3", obs_addr, 16'd7);
        check("ws_busy_cycles", busy_n, 3);
        check("ws_opcode", opcode, 4'hA);
        cyc(1'b0, 1'b1, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ws_once_imm", imm, 16'h1234);
        check("ws_idle", fetch_busy, 1'b0);

        // Abort an outstanding fetch with pc_rst
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("abort_pc", pc_out, 16'h0);
        check("abort_busy", fetch_busy, 1'b0);
        cyc(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("abort_imm", imm, 16'h1234);
        check("abort_opcode", opcode, 4'hA);
`else
        // Single-cycle build: imem_valid is irrelevant
        cyc(1'b1, 1'b0, 32'h76543210, 1'b0, 1'b0, 1'b0, 1'b0);
        check("nostall_imm", imm, 16'h3210);
        check("nostall_opcode", opcode, 4'h7);
        check("nostall_busy", obs_busy, 1'b0);
`endif

        // Randomized traffic against the reference
        repeat (400) begin
            cyc(1'($urandom % 2), 1'($urandom % 2), $urandom, 1'($urandom % 2),
                1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 16) == 0));
        end

        // Asynchronous reset in the middle of a fetch
        cyc(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_pc(16'h0033);
        cyc(1'b1, 1'b0, 32'hC0DE0001, 1'b0, 1'b0, 1'b0, 1'b0);
        ir_load = 1'b0; imem_valid = 1'b0;
        #2;
        rst_f = 1'b0;
        #1;
        model_reset();
        check("arst_pc", pc_out, 16'h0);
        check("arst_opcode", opcode, 4'h0);
        check("arst_busy", fetch_busy, 1'b0);
        check("arst_rd", imem_rd, 1'b0);
        check("arst_addr", imem_addr, 16'h0);
        @(posedge clk);
        #1;
        rst_f = 1'b1;
        cyc(1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sisc_fetch_unit.md
# sisc_fetch_unit

Instruction-fetch stage of the SISC datapath. It holds the program counter and the instruction register, and computes branch targets. It decodes the IR into the opcode, mm, register and immediate fields that drive `ctrl`. It consumes `ctrl`'s `pc_rst`, `pc_write`, `pc_sel`, `br_sel` and `ir_load` strobes, and issues read requests to instruction memory. An optional wait-state handshake lets it stall on slow memory.

## Interface
- `ADDR_W`, default 16: PC, instruction-memory address and immediate width.
- `clk`, input, 1: system clock, rising edge.
- `rst_f`, input, 1: asynchronous, active-low reset.
- `pc_rst`, input, 1: synchronous PC clear from `ctrl`.
- `pc_write`, input, 1: PC update enable.
- `pc_sel`, input, 1: selects the next PC. 0 selects PC+1; 1 selects the branch target.
- `br_sel`, input, 1: selects the branch mode. 1 is absolute (imm); 0 is relative (PC+imm).
- `ir_load`, input, 1: fetch strobe from `ctrl`.
- `imem_rdata`, input, 32: instruction word from memory.
- `imem_valid`, input, 1: `imem_rdata` valid. Used only with `FETCH_STALL_EN`.
- `imem_addr`, output, `ADDR_W`: fetch address.
- `imem_rd`, output, 1: read request.
- `fetch_busy`, output, 1: fetch outstanding. `ctrl` stalls while this is high.
- `pc_out`, output, `ADDR_W`: current PC.
- `opcode`, output, 4: IR[31:28].
- `mm`, output, 4: IR[27:24].
- `rn`, output, 4: IR[23:20].
- `rs`, output, 4: IR[19:16].
- `rt`, output, 4: IR[15:12].
- `imm`, output, `ADDR_W`: IR[`ADDR_W`-1:0].

## Operation
- **Field decode:** all field outputs are combinational slices of IR.
- **Reset values:** `rst_f` low clears all of the following at once:
  - PC and IR to 0, so `opcode` = NOOP and all fields = 0;
  - fetch address register to 0;
  - FSM to IDLE;
  - `imem_rd` and `fetch_busy` to 0;
  - `imem_addr` to 0.
- **PC update** at the clock edge, in priority order:
  1. `pc_rst` = 1: PC becomes 0.
  2. `pc_write` = 1 and `pc_sel` = 0: PC becomes PC+1.
  3. `pc_write` = 1, `pc_sel` = 1, `br_sel` = 1: PC becomes `imm`.
  4. `pc_write` = 1, `pc_sel` = 1, `br_sel` = 0: PC becomes PC+`imm`.
  5. Otherwise: PC holds.
- **PC arithmetic:** unsigned, modulo 2^`ADDR_W`, with no overflow flag.
  - Relative branches add `imm` to the PC value present when `pc_write` is asserted. In the normal flow this is the already-incremented PC.
  - A negative relative branch uses two's-complement `imm`.
- **Fetch FSM states:** IDLE and WAIT.
- **IDLE behaviour:**
  - `imem_addr` = PC and `imem_rd` = `ir_load`.
  - On `ir_load` = 1, the fetch address register captures PC.
  - If `imem_valid` = 1 in the same cycle, IR captures `imem_rdata` and the FSM stays in IDLE. This is a zero-wait fetch.
  - Otherwise the FSM moves to WAIT.
- **WAIT behaviour:**
  - `imem_addr` = fetch address register, `imem_rd` = 1 and `fetch_busy` = 1.
  - On `imem_valid` = 1, IR captures `imem_rdata` and the FSM returns to IDLE.
- **Simultaneous `ir_load` and `pc_write`** (the `ctrl` fetch state): the fetch uses the pre-increment PC. The PC increments on the same edge.
- **`ir_load` during WAIT:** ignored; no second request is queued.
- **`pc_write` during WAIT:** applied normally. The fetch address is unaffected because it was latched at the request.
- **`pc_rst` during WAIT:** the outstanding fetch is aborted. The FSM returns to IDLE, IR holds its old value, and a late `imem_valid` is ignored.
- **`rst_f` asserted mid-fetch:** immediate return to the reset values; no capture occurs.
- **IR outside a capture:** IR holds its value, so the fields stay stable through decode, execute, mem and writeback.

## Timing
- **Zero-wait fetch:** `ir_load` and `imem_valid` are high in cycle N, and the new IR fields are visible after edge N. This is one cycle of latency.
- **k wait states:** `fetch_busy` is high for k cycles, beginning the cycle after `ir_load`. The IR updates on the edge where `imem_valid` = 1.
- **`fetch_busy`:** a combinational decode of state WAIT, with no input-to-output path.
- **PC:** updates on the edge where `pc_write` is sampled; `pc_out` is valid in the next cycle.
- **`imem_addr` and `imem_rd`:** combinational from state, PC, fetch address register and `ir_load`.

## Configuration
- **`FETCH_STALL_EN` defined:** the handshake FSM is built as described above.
- **`FETCH_STALL_EN` undefined:**
  - The FSM is removed and `imem_valid` is ignored.
  - IR captures `imem_rdata` on every edge where `ir_load` = 1, so memory must respond in a single cycle.
  - `fetch_busy` is tied to 0.
  - `imem_rd` = `ir_load` and `imem_addr` = PC.
  - PC behaviour is identical in both configurations.

## Test plan
- **Reset:** pulse `rst_f` low mid-cycle → `pc_out` = 0, `opcode` = 0, `fetch_busy` = 0 and `imem_rd` = 0 immediately, without waiting for a clock edge.
- **Sequential fetch:** PC = 5; `ir_load` + `pc_write` with `pc_sel` = 0; `imem_valid` = 1, `imem_rdata` = 0x81234007 → `imem_addr` = 5, then PC = 6, `opcode` = 8, `mm` = 1, `rn` = 2, `rs` = 3, `rt` = 4, `imm` = 0x4007.
- **Branches:**
  - PC = 0x0010, IR `imm` = 0x0020, `pc_sel` = 1, `br_sel` = 1 → PC = 0x0020.
  - With `br_sel` = 0 → PC = 0x0030.
  - With `br_sel` = 0 and `imm` = 0xFFFE → PC = 0x000E (wrap).
- **Wait states (`FETCH_STALL_EN`):** `ir_load` at PC = 7 with `imem_valid` low for 3 cycles → `fetch_busy` high for exactly 3 cycles and `imem_addr` stays 7. A second `ir_load` during WAIT is ignored, and the IR loads once.
- **Abort:** `pc_rst` during WAIT, then `imem_valid` pulses → state IDLE, PC = 0, IR unchanged.
- **No-stall build:** `FETCH_STALL_EN` undefined, `imem_valid` held 0 → IR still captures on `ir_load` and `fetch_busy` stays 0.
